serial_frame_tx: RTL

Framed serial transmitter. It drives the single-bit line that a downstream enable-gated capture flop samples. It takes a parallel word through a valid/ready handshake and shifts it out LSB-first as start bit, data bits, optional even-parity bit and stop bit. Each bit is held for a fixed number of enabled clock cycles, and a global enable freezes transmission in place.

---
 rtl/serial_frame_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Each bit lasts CLKS_PER_BIT enabled cycles; enable=0 freezes the frame in place.
module serial_frame_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par, par_n;
  logic              line_n;
  logic              done_n;
  logic              bit_end;

  // Ready is deliberately combinational so a word can be taken on the edge after done.
  assign tx_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);
  assign bit_end  = enable && (timer == TMR_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx_line <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par     <= par_n;
      tx_line <= line_n;
      done    <= done_n;
    end
  end

  // Next-state and next-output logic; tx_line is pre-computed for the bit being entered.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    line_n  = tx_line;
    done_n  = 1'b0;

    if (state != IDLE && enable) begin
      timer_n = bit_end ? '0 : timer + TMR_W'(1);
    end

    case (state)
      IDLE: begin
        line_n = 1'b1;
        if (tx_valid) begin
          shift_n = tx_data;
          par_n   = ^tx_data;
          idx_n   = '0;
          timer_n = '0;
          line_n  = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          line_n  = shift[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (PARITY_EN != 0) begin
              line_n  = par;
              state_n = PARITY;
            end else begin
              line_n  = 1'b1;
              state_n = STOP;
            end
          end else begin
            idx_n  = idx + IDX_W'(1);
            line_n = shift_n[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          line_n  = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          line_n  = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        line_n  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule
